// File: rtl/rcu_pll_seq.sv
// PLL lock sequencer and core-reset conditioner for the reset and clock unit.
// Waits a programmable lock time after any PLL (re)configuration, then hands the core mux to the PLL.
module rcu_pll_seq #(
    parameter int RST_HOLD   = 8,
    parameter int LOCK_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wdt_rst_n_i,
    input  logic                  pll_en_i,
    input  logic [2:0]            clk_cfg_i,
    input  logic [4:0]            core_sel_i,
    input  logic [LOCK_WIDTH-1:0] lock_cyc_i,
    input  logic                  sel_ack_i,
    output logic                  sel_pll_o,
    output logic                  pll_strb_o,
    output logic                  busy_o,
    output logic                  core_rst_n_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOCK,
        ST_SWITCH,
        ST_RUN,
        ST_BYPASS
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);

    state_t                state_reg, state_next;
    logic [LOCK_WIDTH-1:0] cnt_reg, cnt_next;
    logic [8:0]            cfg_reg;
    logic [8:0]            cfg_cur;
    logic [LOCK_WIDTH-1:0] lock_load;
    logic                  changed;
    logic                  sel_pll_reg, sel_pll_next;
    logic                  strb_reg, strb_next;
    logic                  busy_reg, busy_next;

    assign cfg_cur   = {pll_en_i, clk_cfg_i, core_sel_i};
    assign changed   = (cfg_cur != cfg_reg);
    // A zero lock time would never expire on the ==1 check, so clamp it to one cycle
    assign lock_load = (lock_cyc_i == '0) ? LOCK_WIDTH'(1) : lock_cyc_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            cfg_reg     <= '0;
            sel_pll_reg <= 1'b0;
            strb_reg    <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cfg_reg     <= cfg_cur;
            sel_pll_reg <= sel_pll_next;
            strb_reg    <= strb_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pll_en_i) begin
                    state_next = ST_LOCK;
                    cnt_next   = lock_load;
                end
            end
            ST_LOCK: begin
                if (!pll_en_i) begin
                    state_next = ST_IDLE;
                end else if (changed) begin
                    cnt_next = lock_load;
                end else if (cnt_reg == LOCK_WIDTH'(1)) begin
                    state_next = ST_SWITCH;
                end else begin
                    cnt_next = cnt_reg - LOCK_WIDTH'(1);
                end
            end
            ST_SWITCH: begin
                if (!pll_en_i || changed) begin
                    state_next = ST_BYPASS;
                end else if (sel_ack_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!pll_en_i || changed) begin
                    state_next = ST_BYPASS;
                end
            end
            ST_BYPASS: begin
                // Stay here until the mux confirms it is back on HFOSC
                if (!sel_ack_i) begin
                    if (pll_en_i) begin
                        state_next = ST_LOCK;
                        cnt_next   = lock_load;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_pll_next = 1'b0;
        strb_next    = 1'b0;
        busy_next    = 1'b0;
        case (state_next)
            ST_LOCK:   busy_next = 1'b1;
            ST_SWITCH: begin
                sel_pll_next = 1'b1;
                busy_next    = 1'b1;
            end
            ST_RUN: begin
                sel_pll_next = 1'b1;
                strb_next    = 1'b1;
            end
            ST_BYPASS: busy_next = 1'b1;
            default:   ;
        endcase
    end

    assign sel_pll_o  = sel_pll_reg;
    assign pll_strb_o = strb_reg;
    assign busy_o     = busy_reg;

    // Core reset: asserted asynchronously by either source, released after sync + hold count
    logic       core_arst_n;
    logic [1:0] rst_sync_reg;
    logic [7:0] hold_cnt_reg;
    logic       core_rst_n_reg;

    assign core_arst_n = rst_n_i & wdt_rst_n_i;

    always_ff @(posedge clk_i or negedge core_arst_n) begin
        if (!core_arst_n) begin
            rst_sync_reg   <= 2'b00;
            hold_cnt_reg   <= 8'd0;
            core_rst_n_reg <= 1'b0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
            if (rst_sync_reg[1] && !core_rst_n_reg) begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    core_rst_n_reg <= 1'b1;
                end else begin
                    hold_cnt_reg <= hold_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign core_rst_n_o = core_rst_n_reg;

endmodule

// File: tb/tb_rcu_pll_seq.sv
// Directed bench for rcu_pll_seq: reset release, lock/relock timing, disable and watchdog paths.
module tb_rcu_pll_seq;

    logic        clk_i;
    logic        rst_n_i;
    logic        wdt_rst_n_i;
    logic        pll_en_i;
    logic [2:0]  clk_cfg_i;
    logic [4:0]  core_sel_i;
    logic [15:0] lock_cyc_i;
    logic        sel_ack_i;
    logic        sel_pll_o;
    logic        pll_strb_o;
    logic        busy_o;
    logic        core_rst_n_o;

    int total = 0;
    int bad   = 0;
    bit ack_follow = 1'b0;

    rcu_pll_seq #(
        .RST_HOLD  (8),
        .LOCK_WIDTH(16)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wdt_rst_n_i (wdt_rst_n_i),
        .pll_en_i    (pll_en_i),
        .clk_cfg_i   (clk_cfg_i),
        .core_sel_i  (core_sel_i),
        .lock_cyc_i  (lock_cyc_i),
        .sel_ack_i   (sel_ack_i),
        .sel_pll_o   (sel_pll_o),
        .pll_strb_o  (pll_strb_o),
        .busy_o      (busy_o),
        .core_rst_n_o(core_rst_n_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("chk  %s: got=%0h (t=%0t)", tag, got, $time);
        end
    endtask

    // One rising edge; outputs are observed 1 ns later. The mux model echoes sel_pll_o one cycle late.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
            if (ack_follow) sel_ack_i = sel_pll_o;
        end
    endtask

    task automatic check_outs(input string tag, input logic sel, input logic strb, input logic busy);
        check({tag, ".sel"},  {31'd0, sel_pll_o},  {31'd0, sel});
        check({tag, ".strb"}, {31'd0, pll_strb_o}, {31'd0, strb});
        check({tag, ".busy"}, {31'd0, busy_o},     {31'd0, busy});
    endtask

    initial begin
        rst_n_i     = 1'b0;
        wdt_rst_n_i = 1'b1;
        pll_en_i    = 1'b0;
        clk_cfg_i   = 3'd3;
        core_sel_i  = 5'd0;
        lock_cyc_i  = 16'd16;
        sel_ack_i   = 1'b0;

        #1;
        check_outs("reset", 1'b0, 1'b0, 1'b0);
        check("reset.core", {31'd0, core_rst_n_o}, 32'd0);
        tick(3);

        // Reset release: core reset rises on edge RST_HOLD+2 = 10
        rst_n_i = 1'b1;
        tick(9);
        check("rel.core_e9", {31'd0, core_rst_n_o}, 32'd0);
        tick(1);
        check("rel.core_e10", {31'd0, core_rst_n_o}, 32'd1);
        check_outs("rel", 1'b0, 1'b0, 1'b0);

        // Lock sequence, 16 cycles
        ack_follow = 1'b1;
        pll_en_i = 1'b1;
        tick(1);
        check_outs("lock.e0", 1'b0, 1'b0, 1'b1);
        tick(15);
        check_outs("lock.e15", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("lock.e16", 1'b1, 1'b0, 1'b1);
        tick(1);
        check_outs("lock.run", 1'b1, 1'b1, 1'b0);

        // Reconfigure from RUN: drop, bypass, full relock
        clk_cfg_i = 3'd5;
        tick(1);
        check_outs("recfg.byp", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("recfg.lock", 1'b0, 1'b0, 1'b1);
        tick(15);
        check_outs("recfg.e15", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("recfg.e16", 1'b1, 1'b0, 1'b1);
        tick(1);
        check_outs("recfg.run", 1'b1, 1'b1, 1'b0);

        // Disable from RUN back to IDLE, then a zero lock time gives one LOCK cycle
        pll_en_i = 1'b0;
        tick(2);
        check_outs("off.idle", 1'b0, 1'b0, 1'b0);
        lock_cyc_i = 16'd0;
        pll_en_i = 1'b1;
        tick(1);
        check_outs("zero.lock", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("zero.sw", 1'b1, 1'b0, 1'b1);
        tick(1);
        check_outs("zero.run", 1'b1, 1'b1, 1'b0);

        // Mid-lock change restarts the full 20-cycle wait
        pll_en_i = 1'b0;
        tick(2);
        lock_cyc_i = 16'd20;
        pll_en_i = 1'b1;
        tick(1);
        tick(9);
        core_sel_i = 5'd1;
        tick(1);
        check_outs("mid.chg", 1'b0, 1'b0, 1'b1);
        tick(19);
        check_outs("mid.e19", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("mid.e20", 1'b1, 1'b0, 1'b1);
        tick(1);
        check_outs("mid.run", 1'b1, 1'b1, 1'b0);

        // Disable in SWITCH before the ack: bypass until ack drops, strobe never raised
        pll_en_i = 1'b0;
        tick(2);
        ack_follow = 1'b0;
        sel_ack_i  = 1'b0;
        lock_cyc_i = 16'd2;
        pll_en_i   = 1'b1;
        tick(2);
        check_outs("dis.lock", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("dis.sw", 1'b1, 1'b0, 1'b1);
        pll_en_i  = 1'b0;
        sel_ack_i = 1'b1;
        tick(1);
        check_outs("dis.byp", 1'b0, 1'b0, 1'b1);
        tick(1);
        check_outs("dis.hold", 1'b0, 1'b0, 1'b1);
        sel_ack_i = 1'b0;
        tick(1);
        check_outs("dis.idle", 1'b0, 1'b0, 1'b0);

        // Watchdog glitch while in RUN
        ack_follow = 1'b1;
        lock_cyc_i = 16'd3;
        pll_en_i   = 1'b1;
        tick(5);
        check_outs("wdt.run", 1'b1, 1'b1, 1'b0);
        wdt_rst_n_i = 1'b0;
        #1;
        check("wdt.core_async", {31'd0, core_rst_n_o}, 32'd0);
        #2;
        wdt_rst_n_i = 1'b1;
        tick(9);
        check("wdt.core_e9", {31'd0, core_rst_n_o}, 32'd0);
        check("wdt.strb_e9", {31'd0, pll_strb_o}, 32'd1);
        tick(1);
        check("wdt.core_e10", {31'd0, core_rst_n_o}, 32'd1);
        check_outs("wdt.after", 1'b1, 1'b1, 1'b0);

        // Async external reset mid-RUN
        #2;
        rst_n_i = 1'b0;
        #1;
        check_outs("arst", 1'b0, 1'b0, 1'b0);
        check("arst.core", {31'd0, core_rst_n_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
